// File: rtl/rib_wb_pkg.sv
// Shared types and defaults for the RIB-to-Wishbone data bridge.
package rib_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/rib_wb_data_bridge.sv
// RIB data port to Wishbone classic single-beat master; stalls the core via rib_hold_o.
// Optional bus timeout enabled with `RIB_WB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no access; hold follows req, a req launches the bus cycle
// WAIT  | cyc/stb asserted, waiting for ack (or timeout)
// RESP  | read data presented to core, hold released, no relaunch
module rib_wb_data_bridge
  import rib_wb_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0]  ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rib_req_i,
  input  logic                  rib_we_i,
  input  logic [ADDR_WIDTH-1:0] rib_addr_i,
  input  logic [DATA_WIDTH-1:0] rib_data_i,
  output logic [DATA_WIDTH-1:0] rib_data_o,
  output logic                  rib_hold_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  wb_ack_i,
  output logic                  err_o
);

  bridge_state_t         state_q, state_d;
  logic                  launch, complete, expire, timeout_hit;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rib_hold_o = 1'b0;
    launch     = 1'b0;
    complete   = 1'b0;
    expire     = 1'b0;
    case (state_q)
      IDLE: begin
        rib_hold_o = rib_req_i;
        if (rib_req_i) begin
          launch  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        rib_hold_o = 1'b1;
        // ack in the expiry cycle takes priority over the timeout
        if (wb_ack_i) begin
          complete = 1'b1;
          state_d  = RESP;
        end else if (timeout_hit) begin
          expire  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
    end else if (launch) begin
      wb_cyc_o  <= 1'b1;
      wb_stb_o  <= 1'b1;
      wb_we_o   <= rib_we_i;
      wb_addr_o <= rib_addr_i;
      wb_data_o <= rib_data_i;
    end else if (complete || expire) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end
  end

`ifdef RIB_WB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q;

  // counter value equals the number of WAIT cycles already elapsed
  assign timeout_hit = (tmo_cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= expire;
      if (launch)                tmo_cnt_q <= '0;
      else if (state_q == WAIT)  tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                       rdata_q <= '0;
    else if (complete && !wb_we_o) rdata_q <= wb_data_i;
    else if (expire)               rdata_q <= ERR_DATA;
  end

  assign err_o = err_q;
`else
  assign timeout_hit = 1'b0;

  always_ff @(posedge clk) begin
    if (rst)                       rdata_q <= '0;
    else if (complete && !wb_we_o) rdata_q <= wb_data_i;
  end

  assign err_o = 1'b0;
`endif

  assign rib_data_o = rdata_q;

endmodule

// File: tb/tb_rib_wb_data_bridge.sv
// Directed bench for rib_wb_data_bridge with a read-data scoreboard.
// Timeout scenario only runs when RIB_WB_TIMEOUT_EN is defined.
module tb_rib_wb_data_bridge;

  localparam logic [31:0] TB_ERR_DATA = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rib_req, rib_we, rib_hold, wb_cyc, wb_stb, wb_we, wb_ack, err;
  logic [31:0] rib_addr, rib_wdata, rib_rdata, wb_addr, wb_wdata, wb_rdata;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] sb_q[$];
  int          stb_rises = 0;
  logic        stb_prev = 1'b0;

  always #5 clk = ~clk;

  rib_wb_data_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .ERR_DATA(TB_ERR_DATA)
  ) dut (
    .clk(clk), .rst(rst),
    .rib_req_i(rib_req), .rib_we_i(rib_we), .rib_addr_i(rib_addr), .rib_data_i(rib_wdata),
    .rib_data_o(rib_rdata), .rib_hold_o(rib_hold),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_addr_o(wb_addr),
    .wb_data_o(wb_wdata), .wb_data_i(wb_rdata), .wb_ack_i(wb_ack), .err_o(err)
  );

  always @(posedge clk) begin
    if (wb_stb && !stb_prev) stb_rises = stb_rises + 1;
    stb_prev = wb_stb;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_resp(input string tag);
    if (sb_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
    else check(tag, rib_rdata, sb_q.pop_front());
  endtask

  // One access from IDLE; ack arrives after ack_delay idle WAIT cycles.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int ack_delay, input logic keep_req);
    check("idle_cyc", wb_cyc, 1'b0);
    rib_req = 1'b1; rib_we = we; rib_addr = addr; rib_wdata = wdata;
    if (!we) exp_rdata = rdata;
    sb_q.push_back(exp_rdata);
    #1 check("idle_hold", rib_hold, 1'b1);
    step();
    for (int i = 0; i <= ack_delay; i++) begin
      check("wait_cyc", wb_cyc, 1'b1);
      check("wait_stb", wb_stb, 1'b1);
      check("wait_we", wb_we, we);
      check("wait_addr", wb_addr, addr);
      check("wait_wdata", wb_wdata, wdata);
      check("wait_hold", rib_hold, 1'b1);
      if (i == ack_delay) begin wb_ack = 1'b1; wb_rdata = rdata; end
      else                begin wb_ack = 1'b0; wb_rdata = ~rdata; end
      step();
      wb_ack = 1'b0;
    end
    check("resp_cyc", wb_cyc, 1'b0);
    check("resp_stb", wb_stb, 1'b0);
    check("resp_hold", rib_hold, 1'b0);
    check("resp_err", err, 1'b0);
    pop_resp("resp_data");
    step();
    if (!keep_req) rib_req = 1'b0;
  endtask

  initial begin
    int base, n;
    rst = 1'b1; rib_req = 1'b0; rib_we = 1'b0; rib_addr = '0; rib_wdata = '0;
    wb_ack = 1'b0; wb_rdata = '0;
    step(); step();
    rst = 1'b0;
    step();

    // reset state
    check("rst_cyc", wb_cyc, 1'b0);
    check("rst_stb", wb_stb, 1'b0);
    check("rst_we", wb_we, 1'b0);
    check("rst_addr", wb_addr, 32'h0);
    check("rst_wdata", wb_wdata, 32'h0);
    check("rst_rdata", rib_rdata, 32'h0);
    check("rst_hold", rib_hold, 1'b0);
    check("rst_err", err, 1'b0);

    // 1: read, same-cycle ack
    access(1'b0, 32'h100, 32'h0, 32'hCAFE_F00D, 0, 1'b0);

    // 2: write, ack after 4 wait cycles; read data must stay
    access(1'b1, 32'h200, 32'h1234_5678, 32'h5555_AAAA, 4, 1'b0);

    // 3: back-to-back reads with req held through RESP
    step();
    base = stb_rises;
    access(1'b0, 32'h10, 32'h0, 32'h1111_0010, 0, 1'b1);
    access(1'b0, 32'h14, 32'h0, 32'h2222_0014, 1, 1'b0);
    step(); step();
    check("b2b_stb_count", stb_rises - base, 2);
    check("b2b_idle_cyc", wb_cyc, 1'b0);

    // flush: req dropped mid-WAIT, access still completes
    rib_req = 1'b1; rib_we = 1'b0; rib_addr = 32'h400;
    exp_rdata = 32'h0000_ABCD;
    sb_q.push_back(exp_rdata);
    step();
    rib_req = 1'b0;
    #1 check("flush_hold", rib_hold, 1'b1);
    check("flush_cyc", wb_cyc, 1'b1);
    wb_ack = 1'b1; wb_rdata = 32'h0000_ABCD;
    step();
    wb_ack = 1'b0;
    check("flush_resp_cyc", wb_cyc, 1'b0);
    pop_resp("flush_data");
    step();
    check("flush_no_relaunch", wb_cyc, 1'b0);

    // 4: reset during WAIT, late ack ignored
    rib_req = 1'b1; rib_we = 1'b0; rib_addr = 32'h300;
    step();
    check("rstw_cyc_before", wb_cyc, 1'b1);
    step();
    rst = 1'b1; rib_req = 1'b0;
    step();
    check("rstw_cyc", wb_cyc, 1'b0);
    check("rstw_stb", wb_stb, 1'b0);
    check("rstw_hold", rib_hold, 1'b0);
    rst = 1'b0;
    wb_ack = 1'b1; wb_rdata = 32'h7777_7777;
    step();
    check("rstw_late_cyc", wb_cyc, 1'b0);
    check("rstw_late_hold", rib_hold, 1'b0);
    check("rstw_rdata", rib_rdata, 32'h0);
    exp_rdata = 32'h0;

    // 6: ack stuck high in IDLE
    for (int i = 0; i < 3; i++) begin
      step();
      check("ack_idle_cyc", wb_cyc, 1'b0);
      check("ack_idle_hold", rib_hold, 1'b0);
      check("ack_idle_rdata", rib_rdata, 32'h0);
    end
    wb_ack = 1'b0;
    step();

`ifdef RIB_WB_TIMEOUT_EN
    // 5: no ack, abort after 8 WAIT cycles
    rib_req = 1'b1; rib_we = 1'b0; rib_addr = 32'h500;
    sb_q.push_back(TB_ERR_DATA);
    step();
    n = 0;
    while (wb_cyc && n < 20) begin
      check("tmo_err_low", err, 1'b0);
      check("tmo_hold", rib_hold, 1'b1);
      n++;
      step();
    end
    check("tmo_wait_len", n, 8);
    check("tmo_err_pulse", err, 1'b1);
    check("tmo_hold_resp", rib_hold, 1'b0);
    pop_resp("tmo_data");
    step();
    rib_req = 1'b0;
    check("tmo_err_clear", err, 1'b0);
    check("tmo_idle_cyc", wb_cyc, 1'b0);
    exp_rdata = TB_ERR_DATA;
    step();
`else
    // without timeout a silent slave keeps the cycle open
    rib_req = 1'b1; rib_we = 1'b0; rib_addr = 32'h500;
    for (int i = 0; i < 12; i++) step();
    check("notmo_cyc", wb_cyc, 1'b1);
    check("notmo_hold", rib_hold, 1'b1);
    check("notmo_err", err, 1'b0);
    sb_q.push_back(32'h0000_5A5A);
    wb_ack = 1'b1; wb_rdata = 32'h0000_5A5A;
    step();
    wb_ack = 1'b0;
    pop_resp("notmo_data");
    step();
    rib_req = 1'b0;
    step();
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
